cp0_exception_unit: RTL and testbench

- Coprocessor-0 register file and exception/interrupt sequencer for the single-issue MIPS core.
- Sits directly downstream of the instruction decoder and consumes its mtc0/mfc0/eret/Syscall strobes.
- Holds Status, Cause and EPC, and synchronises and edge-detects external interrupt lines.
- Tells the PC-select logic when to redirect to the handler vector or back to EPC.

---
 rtl/cp0_pkg.sv | 56 +++++
 rtl/irq_sync_edge.sv | 40 ++++
 rtl/cp0_exception_unit.sv | 153 +++++++++++++++
 tb/tb_cp0_exception_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
//   Shared definitions for the coprocessor-0 exception unit: CP0 register
//   numbers, field positions, ExcCode values, the packed views of the Status
//   and Cause registers, and helpers that expand them to 32-bit read words.
// -----------------------------------------------------------------------------
package cp0_pkg;

  // CP0 register numbers (rd field of mtc0/mfc0)
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // Field positions inside the 32-bit architectural words
  localparam int IE_BIT  = 0;
  localparam int EXL_BIT = 1;
  localparam int IM_LO   = 8;   // IM in Status and IP in Cause share [10:8]
  localparam int IM_HI   = 10;
  localparam int EXC_LO  = 2;
  localparam int EXC_HI  = 6;

  // ExcCode values
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  // Only the implemented Status bits are stored; everything else reads 0.
  typedef struct packed {
    logic [2:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  // Only the implemented Cause bits are stored; everything else reads 0.
  typedef struct packed {
    logic [2:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  function automatic logic [31:0] status_word(input status_t s);
    logic [31:0] w;
    w = '0;
    w[IM_HI:IM_LO] = s.im;
    w[EXL_BIT]     = s.exl;
    w[IE_BIT]      = s.ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_word(input cause_t c);
    logic [31:0] w;
    w = '0;
    w[IM_HI:IM_LO]   = c.ip;
    w[EXC_HI:EXC_LO] = c.exc_code;
    return w;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
//   Brings one asynchronous, level-sensitive interrupt line into the clk
//   domain through a two-flop synchroniser and emits a one-cycle pulse on
//   each synchronised rising edge. A level held high produces one pulse.
//
//   Ports:
//     clk        in   core clock
//     rst_n      in   asynchronous active-low reset
//     irq_async  in   raw external interrupt line
//     irq_rise   out  single-cycle pulse on a synchronised 0->1 transition
// -----------------------------------------------------------------------------
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_async,
  output logic irq_rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= irq_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign irq_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/cp0_exception_unit.sv
// -----------------------------------------------------------------------------
// cp0_exception_unit
//   Coprocessor-0 register file (Status, Cause, EPC) and exception/interrupt
//   sequencer for the single-issue core. Decides, from pre-edge register
//   state, whether the committing instruction redirects to the handler vector
//   or returns to EPC, and latches interrupt edges into Cause.IP.
//
//   Ports:
//     clk, rst_n    core clock, asynchronous active-low reset
//     commit        current instruction completes this cycle
//     mtc0, mfc0    decoded CP0 move strobes (mfc0 is read-enable only)
//     eret, syscall decoded exception-return / system-call strobes
//     cp0_addr      CP0 register number for mtc0/mfc0
//     wdata         mtc0 write data
//     pc_next       sequential-next PC of the committing instruction
//     irq_in        asynchronous level interrupt lines
//     rdata         combinational CP0 read data
//     exc_take      redirect to exc_vector this cycle
//     exc_vector    handler entry address
//     eret_take     redirect to epc_out this cycle
//     epc_out       current EPC
//     int_pending   any unmasked pending interrupt
// -----------------------------------------------------------------------------
module cp0_exception_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0800,
  parameter logic [31:0] RESET_STATUS = 32'h0000_0701,
  parameter int          N_IRQ        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit,
  input  logic             mtc0,
  input  logic             mfc0,
  input  logic             eret,
  input  logic             syscall,
  input  logic [4:0]       cp0_addr,
  input  logic [31:0]      wdata,
  input  logic [31:0]      pc_next,
  input  logic [N_IRQ-1:0] irq_in,
  output logic [31:0]      rdata,
  output logic             exc_take,
  output logic [31:0]      exc_vector,
  output logic             eret_take,
  output logic [31:0]      epc_out,
  output logic             int_pending
);

  // The sequencer state is Status.EXL itself.
  localparam logic ST_NORMAL  = 1'b0;
  localparam logic ST_HANDLER = 1'b1;

  status_t     status_q, status_d;
  cause_t      cause_q,  cause_d;
  logic [31:0] epc_q,    epc_d;

  logic [N_IRQ-1:0] irq_rise;
  logic             sys_ok;
  logic             int_ok;
  logic             cp0_write;

  // mfc0 only qualifies writeback in the pipeline; the read mux is always live.
  logic unused_mfc0;
  assign unused_mfc0 = mfc0;

  // ---------------------------------------------------------------------------
  // Interrupt synchronisers
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_IRQ; i++) begin : g_irq
    irq_sync_edge u_irq_sync_edge (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_async (irq_in[i]),
      .irq_rise  (irq_rise[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Take decisions from pre-edge state
  // ---------------------------------------------------------------------------
  assign int_pending = |(cause_q.ip & status_q.im);

  assign sys_ok = commit & syscall & (status_q.exl == ST_NORMAL);
  // eret and syscall in the same commit both block an interrupt take.
  assign int_ok = commit & status_q.ie & (status_q.exl == ST_NORMAL)
                & int_pending & ~eret & ~syscall;

  assign exc_take   = sys_ok | int_ok;
  assign eret_take  = commit & eret;
  assign exc_vector = EXC_VECTOR;
  assign epc_out    = epc_q;
  assign cp0_write  = commit & mtc0;

  // ---------------------------------------------------------------------------
  // Next-state: software write first, then IRQ set, then exception overrides
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;

    if (cp0_write) begin
      case (cp0_addr)
        CP0_STATUS: status_d = '{im: wdata[IM_HI:IM_LO], exl: wdata[EXL_BIT], ie: wdata[IE_BIT]};
        // Software can only clear IP bits; ExcCode is read-only.
        CP0_CAUSE:  cause_d.ip = cause_q.ip & wdata[IM_HI:IM_LO];
        CP0_EPC:    epc_d = wdata;
        default:    ;
      endcase
    end

    // Applied after the software clear so a same-cycle edge wins.
    cause_d.ip = cause_d.ip | irq_rise;

    if (exc_take) begin
      status_d.exl     = ST_HANDLER;
      epc_d            = pc_next;
      cause_d.exc_code = sys_ok ? EXC_SYS : EXC_INT;
    end else if (eret_take) begin
      status_d.exl = ST_NORMAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '{im: RESET_STATUS[IM_HI:IM_LO], exl: RESET_STATUS[EXL_BIT],
                    ie: RESET_STATUS[IE_BIT]};
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux over current (pre-edge) registers
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (cp0_addr)
      CP0_STATUS: rdata = status_word(status_q);
      CP0_CAUSE:  rdata = cause_word(cause_q);
      CP0_EPC:    rdata = epc_q;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_exception_unit
//   Self-checking bench: a directed vector table, hand-written multi-cycle
//   sequences (interrupt latency, masking/ack, eret with pending interrupt,
//   async reset mid-handler), then randomized stimulus, all compared against
//   a word-level reference model of the CP0 registers.
// -----------------------------------------------------------------------------
module tb_cp0_exception_unit;

  logic        clk;
  logic        rst_n;
  logic        commit, mtc0, mfc0, eret, syscall;
  logic [4:0]  cp0_addr;
  logic [31:0] wdata, pc_next;
  logic [2:0]  irq_in;
  logic [31:0] rdata, exc_vector, epc_out;
  logic        exc_take, eret_take, int_pending;

  int checks   = 0;
  int failures = 0;

  cp0_exception_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .commit     (commit),
    .mtc0       (mtc0),
    .mfc0       (mfc0),
    .eret       (eret),
    .syscall    (syscall),
    .cp0_addr   (cp0_addr),
    .wdata      (wdata),
    .pc_next    (pc_next),
    .irq_in     (irq_in),
    .rdata      (rdata),
    .exc_take   (exc_take),
    .exc_vector (exc_vector),
    .eret_take  (eret_take),
    .epc_out    (epc_out),
    .int_pending(int_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: architectural words plus a history of sampled irq_in
  // ---------------------------------------------------------------------------
  logic [31:0] m_status, m_cause, m_epc;
  logic [2:0]  h1, h2, h3;   // irq_in sampled at the last three rising edges

  // Values seen during the most recent step, for hand-written checks.
  logic        a_exc, a_eret, a_intp;
  logic [31:0] a_rdata;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_status = 32'h0000_0701;
    m_cause  = 32'h0;
    m_epc    = 32'h0;
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    case (addr)
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // One clock cycle: drive, check combinational outputs, advance the model.
  task automatic step(input logic c, input logic mt, input logic er,
                      input logic sc, input logic [4:0] addr,
                      input logic [31:0] wd, input logic [31:0] pc,
                      input logic [2:0] irq);
    logic        exl, ie, e_sys, e_int, e_exc, e_eret, e_intp;
    logic [2:0]  im, ip, rise;
    logic [31:0] n_status, n_cause, n_epc;

    commit = c; mtc0 = mt; mfc0 = ~mt; eret = er; syscall = sc;
    cp0_addr = addr; wdata = wd; pc_next = pc; irq_in = irq;
    #1;

    exl = m_status[1];
    ie  = m_status[0];
    im  = m_status[10:8];
    ip  = m_cause[10:8];
    e_sys  = c & sc & ~exl;
    e_int  = c & ie & ~exl & (|(ip & im)) & ~er & ~sc;
    e_exc  = e_sys | e_int;
    e_eret = c & er;
    e_intp = |(ip & im);

    a_exc = exc_take; a_eret = eret_take; a_intp = int_pending; a_rdata = rdata;
    check("exc_take",    {31'b0, exc_take},    {31'b0, e_exc});
    check("eret_take",   {31'b0, eret_take},   {31'b0, e_eret});
    check("int_pending", {31'b0, int_pending}, {31'b0, e_intp});
    check("rdata",       rdata,                model_read(addr));
    check("epc_out",     epc_out,              m_epc);
    check("exc_vector",  exc_vector,           32'h0000_0800);

    // Next architectural values from the pre-edge model state.
    rise     = h2 & ~h3;
    n_status = m_status;
    n_cause  = m_cause;
    n_epc    = m_epc;
    if (c && mt) begin
      if (addr == 5'd12) n_status = wd & 32'h0000_0703;
      if (addr == 5'd13) n_cause[10:8] = ip & wd[10:8];
      if (addr == 5'd14) n_epc = wd;
    end
    n_cause[10:8] = n_cause[10:8] | rise;
    if (e_exc) begin
      n_status[1]  = 1'b1;
      n_epc        = pc;
      n_cause[6:2] = e_sys ? 5'd8 : 5'd0;
    end else if (e_eret) begin
      n_status[1] = 1'b0;
    end

    @(posedge clk);
    m_status = n_status;
    m_cause  = n_cause;
    m_epc    = n_epc;
    h3 = h2; h2 = h1; h1 = irq;
    @(negedge clk);
  endtask

  // Plain register read with no commit.
  task automatic rd(input logic [4:0] addr, input logic [2:0] irq);
    step(1'b0, 1'b0, 1'b0, 1'b0, addr, 32'h0, 32'h0, irq);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        c, mt, er, sc;
    logic [4:0]  addr;
    logic [31:0] wd, pc;
    logic        x_exc, x_eret;
    logic [31:0] x_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic mt, input logic er,
                              input logic sc, input logic [4:0] addr,
                              input logic [31:0] wd, input logic [31:0] pc,
                              input logic x_exc, input logic x_eret,
                              input logic [31:0] x_rdata);
    vec_t v;
    v.c = c; v.mt = mt; v.er = er; v.sc = sc; v.addr = addr; v.wd = wd;
    v.pc = pc; v.x_exc = x_exc; v.x_eret = x_eret; v.x_rdata = x_rdata;
    return v;
  endfunction

  initial begin
    model_reset();
    rst_n = 1'b0;
    commit = 0; mtc0 = 0; mfc0 = 0; eret = 0; syscall = 0;
    cp0_addr = 5'd12; wdata = '0; pc_next = '0; irq_in = '0;

    //          c  mt er sc addr   wdata          pc            exc eret rdata
    vecs.push_back(mk(0, 0, 0, 0, 5'd12, 32'h0,         32'h0,        0, 0, 32'h701));
    vecs.push_back(mk(0, 0, 0, 0, 5'd13, 32'h0,         32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 5'd14, 32'h0,         32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 1, 5'd12, 32'h0,         32'h3010,     1, 0, 32'h701));
    vecs.push_back(mk(0, 0, 0, 0, 5'd14, 32'h0,         32'h0,        0, 0, 32'h3010));
    vecs.push_back(mk(0, 0, 0, 0, 5'd12, 32'h0,         32'h0,        0, 0, 32'h703));
    vecs.push_back(mk(0, 0, 0, 0, 5'd13, 32'h0,         32'h0,        0, 0, 32'h20));
    vecs.push_back(mk(1, 0, 0, 1, 5'd14, 32'h0,         32'h4000,     0, 0, 32'h3010));
    vecs.push_back(mk(0, 0, 0, 0, 5'd14, 32'h0,         32'h0,        0, 0, 32'h3010));
    vecs.push_back(mk(1, 0, 1, 0, 5'd12, 32'h0,         32'h0,        0, 1, 32'h703));
    vecs.push_back(mk(0, 0, 0, 0, 5'd12, 32'h0,         32'h0,        0, 0, 32'h701));
    vecs.push_back(mk(1, 0, 1, 0, 5'd13, 32'h0,         32'h0,        0, 1, 32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 5'd12, 32'h0,         32'h0,        0, 0, 32'h701));
    vecs.push_back(mk(1, 1, 0, 0, 5'd13, 32'hFFFF_FFFF, 32'h0,        0, 0, 32'h20));
    vecs.push_back(mk(0, 0, 0, 0, 5'd13, 32'h0,         32'h0,        0, 0, 32'h20));
    vecs.push_back(mk(1, 1, 0, 0, 5'd14, 32'h1234_5678, 32'h0,        0, 0, 32'h3010));
    vecs.push_back(mk(0, 0, 0, 0, 5'd14, 32'h0,         32'h0,        0, 0, 32'h1234_5678));
    vecs.push_back(mk(1, 1, 0, 0, 5'd12, 32'hFFFF_FFFF, 32'h0,        0, 0, 32'h701));
    vecs.push_back(mk(0, 0, 0, 0, 5'd12, 32'h0,         32'h0,        0, 0, 32'h703));
    vecs.push_back(mk(1, 0, 1, 0, 5'd12, 32'h0,         32'h0,        0, 1, 32'h703));
    vecs.push_back(mk(0, 0, 0, 0, 5'd12, 32'h0,         32'h0,        0, 0, 32'h701));
    vecs.push_back(mk(1, 1, 0, 0, 5'd5,  32'hFFFF_FFFF, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 5'd12, 32'h0,         32'h0,        0, 0, 32'h701));
    vecs.push_back(mk(0, 1, 0, 0, 5'd14, 32'h0,         32'h0,        0, 0, 32'h1234_5678));
    vecs.push_back(mk(0, 0, 0, 0, 5'd14, 32'h0,         32'h0,        0, 0, 32'h1234_5678));
    vecs.push_back(mk(0, 0, 1, 0, 5'd12, 32'h0,         32'h0,        0, 0, 32'h701));
    vecs.push_back(mk(0, 0, 0, 1, 5'd12, 32'h0,         32'h0,        0, 0, 32'h701));
    vecs.push_back(mk(0, 0, 0, 0, 5'd12, 32'h0,         32'h0,        0, 0, 32'h701));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].c, vecs[i].mt, vecs[i].er, vecs[i].sc, vecs[i].addr,
           vecs[i].wd, vecs[i].pc, 3'b000);
      check($sformatf("vec%0d_exc", i),   {31'b0, a_exc},  {31'b0, vecs[i].x_exc});
      check($sformatf("vec%0d_eret", i),  {31'b0, a_eret}, {31'b0, vecs[i].x_eret});
      check($sformatf("vec%0d_rdata", i), a_rdata,         vecs[i].x_rdata);
    end

    // --- Interrupt latency: irq_in[1] rises before edge k, commit held ---
    step(1, 0, 0, 0, 5'd13, 32'h0, 32'h5000, 3'b010);       // edge k
    check("irq_k_exc", {31'b0, a_exc}, 32'h0);
    step(1, 0, 0, 0, 5'd13, 32'h0, 32'h5004, 3'b010);       // edge k+1
    check("irq_k1_cause", a_rdata, 32'h20);
    step(1, 0, 0, 0, 5'd13, 32'h0, 32'h5008, 3'b010);       // edge k+2
    check("irq_k2_exc", {31'b0, a_exc}, 32'h0);
    step(1, 0, 0, 0, 5'd13, 32'h0, 32'h500C, 3'b010);
    check("irq_cause_ip", a_rdata, 32'h220);
    check("irq_take", {31'b0, a_exc}, 32'h1);
    rd(5'd14, 3'b010);
    check("irq_epc", a_rdata, 32'h500C);
    rd(5'd13, 3'b010);
    check("irq_exccode", a_rdata, 32'h200);

    // --- Masking and acknowledge ---
    step(1, 1, 0, 0, 5'd12, 32'h503, 32'h0, 3'b010);        // IM[1]=0, stay in handler
    step(1, 0, 1, 0, 5'd12, 32'h0,   32'h0, 3'b010);        // eret
    check("mask_eret", {31'b0, a_eret}, 32'h1);
    step(1, 0, 0, 0, 5'd13, 32'h0, 32'h5100, 3'b010);
    check("mask_no_take", {31'b0, a_exc}, 32'h0);
    check("mask_intp", {31'b0, a_intp}, 32'h0);
    rd(5'd13, 3'b110);                                      // irq_in[2] rises
    rd(5'd13, 3'b110);
    step(1, 1, 0, 0, 5'd13, 32'h0, 32'h0, 3'b110);          // clear meets edge
    check("clr_edge_no_take", {31'b0, a_exc}, 32'h0);
    rd(5'd13, 3'b110);
    check("clr_edge_ip2", a_rdata, 32'h400);
    check("clr_edge_intp", {31'b0, a_intp}, 32'h1);
    step(1, 1, 0, 0, 5'd13, 32'h0, 32'h6000, 3'b110);       // clear, IP2 taken
    check("ack_take", {31'b0, a_exc}, 32'h1);
    rd(5'd13, 3'b110);
    check("ack_cause", a_rdata, 32'h0);
    check("ack_intp", {31'b0, a_intp}, 32'h0);

    // --- eret with a pending interrupt ---
    rd(5'd13, 3'b111);
    rd(5'd13, 3'b111);
    rd(5'd13, 3'b111);
    rd(5'd13, 3'b111);
    check("eret_ip0", a_rdata, 32'h100);
    step(1, 0, 1, 0, 5'd12, 32'h0, 32'h0, 3'b111);
    check("eret_pend_eret", {31'b0, a_eret}, 32'h1);
    check("eret_pend_noexc", {31'b0, a_exc}, 32'h0);
    rd(5'd12, 3'b111);
    check("eret_pend_status", a_rdata, 32'h501);
    step(1, 0, 0, 0, 5'd12, 32'h0, 32'h3010, 3'b111);
    check("eret_next_take", {31'b0, a_exc}, 32'h1);

    // --- Asynchronous reset mid-handler ---
    cp0_addr = 5'd12; commit = 1'b0;
    #1;
    check("pre_rst_status", rdata, 32'h503);
    check("pre_rst_epc", epc_out, 32'h3010);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_status", rdata, 32'h701);
    check("async_rst_epc", epc_out, 32'h0);
    cp0_addr = 5'd13;
    #1;
    check("async_rst_cause", rdata, 32'h0);
    check("async_rst_exc", {31'b0, exc_take}, 32'h0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // --- Randomized stimulus against the model ---
    for (int n = 0; n < 500; n++) begin
      logic        c, mt, er, sc;
      logic [4:0]  addr;
      logic [2:0]  irq;
      int          op;
      c  = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 7);
      sc = (op == 0);
      er = (op == 1);
      mt = (op == 2) || (op == 3);
      case ($urandom_range(0, 3))
        0: addr = 5'd12;
        1: addr = 5'd13;
        2: addr = 5'd14;
        default: addr = 5'($urandom);
      endcase
      irq = ($urandom_range(0, 7) == 0) ? 3'($urandom) : irq_in;
      step(c, mt, er, sc, addr, $urandom, $urandom, irq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
